// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem read per accepted PC, results queued
// for decode as {instr, pc, misalign} in a small FIFO with a registered head.
module instr_fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_misalign,
  input  logic        instr_ready
);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = 65;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DISCARD} state_t;

  state_t             state_reg, state_next;
  logic [29:0]        addr_word_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head_reg, head_next;
  logic [ENTRY_W-1:0] push_entry;
  logic               accept, aligned, push, pop;
  logic [CNT_W-1:0]   remaining;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign aligned = (pc[1:0] == 2'b00);
  assign accept  = pc_valid && pc_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && aligned) state_next = REQ;
      end
      REQ: begin
        if (flush)         state_next = imem_gnt ? DISCARD : IDLE;
        else if (imem_gnt) state_next = RSP;
      end
      RSP: begin
        if (imem_rvalid) state_next = IDLE;
        else if (flush)  state_next = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs; pc_ready is held low while reset is asserted
  always_comb begin
    pc_ready = 1'b0;
    imem_req = 1'b0;
    case (state_reg)
      IDLE:    pc_ready = (count_reg < DEPTH_CNT) && !flush && !rst;
      REQ:     imem_req = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   addr_word_reg <= '0;
    else if (accept && aligned) addr_word_reg <= pc[31:2];
  end

  assign imem_addr = {addr_word_reg, 2'b00};

  // Misaligned fetches bypass memory; a response is pushed only outside a flush cycle
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (accept && !aligned) begin
      push       = 1'b1;
      push_entry = {NOP_INSTR, pc, 1'b1};
    end else if (state_reg == RSP && imem_rvalid && !flush) begin
      push       = 1'b1;
      push_entry = {imem_rdata, addr_word_reg, 2'b00, 1'b0};
    end
  end

  assign pop       = (count_reg != '0) && instr_ready && !flush;
  assign remaining = pop ? count_reg - 1'b1 : count_reg;

  always_comb begin
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next  = push ? remaining + 1'b1 : remaining;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  // Head register: takes the pushed word when it lands in an empty queue,
  // otherwise the next stored entry after a pop.
  always_comb begin
    head_next = head_reg;
    if (push && remaining == '0)
      head_next = push_entry;
    else if (pop && count_reg > CNT_W'(1))
      head_next = fifo_mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      head_reg   <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      head_reg   <= head_next;
    end
  end

  assign instr_valid    = (count_reg != '0);
  assign instr          = head_reg[64:33];
  assign instr_pc       = head_reg[32:1];
  assign instr_misalign = head_reg[0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, checked against
// a transaction-level model (expected-output queue and one tracked fetch).
module tb_instr_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, pc_ready, flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_misalign, instr_ready;
  logic [31:0] instr, instr_pc;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_misalign(instr_misalign),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] popped_pc[$];
  int          total = 0;
  int          bad   = 0;
  bit          busy, granted, killed, last_acc;
  logic [31:0] fetch_pc;
  bit          auto_mem, mem_pend;
  int          gnt_pct, max_delay, mem_cnt, lat;
  logic [31:0] mem_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    busy     = 1'b0;
    granted  = 1'b0;
    killed   = 1'b0;
    mem_pend = 1'b0;
  endfunction

  // One clock cycle: inputs already set at the falling edge; check, update model, advance.
  task automatic tick();
    bit     exp_ready, pop, acc, req_exp;
    entry_t e;
    if (auto_mem) begin
      imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
      imem_rvalid = mem_pend && (mem_cnt == 1);
      imem_rdata  = mem_pend ? mem_data : $urandom;
    end
    #1;
    exp_ready = !busy && (exp_q.size() < DEPTH) && !flush;
    req_exp   = busy && !granted;
    chk("pc_ready", pc_ready, exp_ready);
    chk("imem_req", imem_req, req_exp);
    if (req_exp) chk("imem_addr", imem_addr, {fetch_pc[31:2], 2'b00});
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("instr", instr, exp_q[0].instr);
      chk("instr_pc", instr_pc, exp_q[0].pc);
      chk("instr_misalign", instr_misalign, exp_q[0].mis);
    end
    acc      = pc_valid && exp_ready;
    last_acc = acc;
    pop      = (exp_q.size() != 0) && instr_ready && !flush;
    if (pop) begin
      e = exp_q.pop_front();
      popped_pc.push_back(e.pc);
      $display("pop pc=%08h instr=%08h mis=%0d", e.pc, e.instr, e.mis);
    end
    if (busy && !granted) begin
      if (flush && !imem_gnt) busy = 1'b0;
      else begin
        if (imem_gnt) granted = 1'b1;
        if (flush)    killed  = 1'b1;
      end
    end else if (busy && granted) begin
      if (imem_rvalid) begin
        if (!killed && !flush) exp_q.push_back('{imem_rdata, fetch_pc, 1'b0});
        busy = 1'b0;
      end else if (flush) killed = 1'b1;
    end
    if (acc) begin
      if (pc[1:0] != 2'b00) exp_q.push_back('{NOP, pc, 1'b1});
      else begin
        busy = 1'b1; granted = 1'b0; killed = 1'b0; fetch_pc = pc;
      end
    end
    if (flush) exp_q.delete();
    if (auto_mem) begin
      if (mem_pend) begin
        if (imem_rvalid) mem_pend = 1'b0;
        else             mem_cnt--;
      end
      if (imem_req && imem_gnt) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(max_delay, 1);
        mem_data = $urandom;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    bit got = 1'b0;
    pc = a;
    pc_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    pc_valid = 1'b0;
    chk("accept_timeout", got, 1'b1);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2;
    rst = 1'b1;
    pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("rst_pc_ready", pc_ready, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_misalign", instr_misalign, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pc = '0; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b1;
    auto_mem = 1'b1; gnt_pct = 100; max_delay = 1;
    model_reset();
    do_reset();

    // Zero-wait fetches of 0x0, 0x4, 0x8 with latency of the first
    popped_pc.delete();
    fetch(32'h0);
    lat = 1;
    while (!instr_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    fetch(32'h4);
    fetch(32'h8);
    idle(5);
    chk("seq_count", popped_pc.size(), 3);
    if (popped_pc.size() == 3) begin
      chk("seq_pc0", popped_pc[0], 32'h0);
      chk("seq_pc1", popped_pc[1], 32'h4);
      chk("seq_pc2", popped_pc[2], 32'h8);
    end

    // Back-pressure: FIFO fills at two entries, head holds, then drains
    popped_pc.delete();
    instr_ready = 1'b0;
    fetch(32'h10);
    fetch(32'h14);
    pc = 32'h18;
    pc_valid = 1'b1;
    repeat (4) begin
      tick();
      chk("full_no_accept", last_acc, 1'b0);
      chk("full_pc_ready", pc_ready, 1'b0);
      chk("full_head_pc", instr_pc, 32'h10);
    end
    instr_ready = 1'b1;
    fetch(32'h18);
    idle(6);
    chk("drain_count", popped_pc.size(), 3);
    if (popped_pc.size() == 3) begin
      chk("drain_pc0", popped_pc[0], 32'h10);
      chk("drain_pc1", popped_pc[1], 32'h14);
      chk("drain_pc2", popped_pc[2], 32'h18);
    end

    // Flush while waiting for the response; late 0xDEADBEEF is dropped
    auto_mem = 1'b0; mem_pend = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    pc = 32'h20; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("discard_pc_ready", pc_ready, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("after_discard_pc_ready", pc_ready, 1'b1);
    chk("after_discard_valid", instr_valid, 1'b0);
    tick();
    chk("dropped_stays_empty", instr_valid, 1'b0);

    // Flush while requesting without grant; request withdrawn, 0x100 fetched normally
    pc = 32'h40; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; flush = 1'b1; imem_gnt = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("withdrawn_req", imem_req, 1'b0);
    chk("withdrawn_pc_ready", pc_ready, 1'b1);
    auto_mem = 1'b1; mem_pend = 1'b0;
    popped_pc.delete();
    fetch(32'h100);
    idle(5);
    chk("redirect_count", popped_pc.size(), 1);
    if (popped_pc.size() == 1) chk("redirect_pc", popped_pc[0], 32'h100);

    // Misaligned PC substitutes a NOP without touching memory
    instr_ready = 1'b0;
    fetch(32'h102);
    chk("mis_req", imem_req, 1'b0);
    chk("mis_valid", instr_valid, 1'b1);
    chk("mis_instr", instr, 32'h00000013);
    chk("mis_pc", instr_pc, 32'h102);
    chk("mis_flag", instr_misalign, 1'b1);
    instr_ready = 1'b1;
    idle(2);

    // Reset during the response wait; stale rvalid afterwards is ignored
    auto_mem = 1'b0; mem_pend = 1'b0; imem_gnt = 1'b0;
    pc = 32'h60; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_reset();
    imem_rvalid = 1'b1; imem_rdata = 32'h55AA55AA;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", instr_valid, 1'b0);
    chk("stale_instr", instr, 32'h0);
    auto_mem = 1'b1; mem_pend = 1'b0;
    popped_pc.delete();
    fetch(32'h64);
    idle(5);
    chk("post_rst_count", popped_pc.size(), 1);
    if (popped_pc.size() == 1) chk("post_rst_pc", popped_pc[0], 32'h64);

    // Random traffic: variable grant/response latency, back-pressure, flushes
    gnt_pct = 60; max_delay = 3;
    for (int i = 0; i < 800; i++) begin
      pc_valid    = ($urandom_range(1) == 1);
      pc          = $urandom_range(1023);
      if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
      instr_ready = ($urandom_range(9) < 6);
      flush       = ($urandom_range(19) == 0);
      tick();
    end
    pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    idle(12);
    chk("final_empty", instr_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
